array_stream_packer: RTL and testbench
======================================

// Module: array_stream_packer
// PURPOSE
//  Upstream feeder for the array-reversal stage. Collects N WIDTH-bit words
//  arriving serially on a valid/ready stream and packs them into one flat
//  array word. Presents the complete array with valid/ready and holds it
//  stable until the downstream reversal stage (or its register) accepts it.
// PARAMETERS
//  N      5  elements per array; legal range N >= 1
//  WIDTH  8  bits per element; legal range WIDTH >= 1
//  CNT_W  derived: max(1, $clog2(N)); element index counter width
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous reset, active-high
//  in_valid   in   1        input word valid
//  in_ready   out  1        packer can accept a word
//  in_data    in   WIDTH    input word
//  out_valid  out  1        complete array available
//  out_ready  in   1        downstream accepts the array
//  out_flat   out  N*WIDTH  packed array; element i = out_flat[i*WIDTH +: WIDTH]
//  out_sum    out  WIDTH    element checksum; present only with ARRAY_PACK_CHECKSUM_EN
// BEHAVIOUR
//  Clocking/reset: one clock, clk. rst is asynchronous and active-high.
//  Reset values: state=FILL, count=0, out_valid=0, out_flat=0, out_sum=0.
//   After reset in_ready=1.
//  Reset mid-fill or mid-hold: the partial or held array is discarded.
//   There is no flush-on-deassert and no replay.
//  States:
//   FILL: in_ready=1, out_valid=0.
//    On in_valid&&in_ready: element[count] <= in_data.
//    If count==N-1: count<=0, go to HOLD. Otherwise count<=count+1.
//   HOLD: in_ready=0, out_valid=1, out_flat frozen.
//    On out_ready: go to FILL. in_ready rises the next cycle.
//  in_ready is decoded from state only. It has no combinational path from
//   out_ready, and there is no same-cycle bypass.
//  Ordering: the first word accepted after FILL entry goes to element 0.
//   The Nth word goes to element N-1.
//  Latency: out_valid asserts on the clock edge that captures the Nth word.
//   It is visible the cycle after that word's handshake.
//  Throughput: N+1 cycles per array minimum (N fill cycles + 1 hold cycle),
//   with in_valid and out_ready held high.
//  in_valid low in FILL: count and elements hold. Gaps are allowed anywhere.
//  out_ready low in HOLD: array held indefinitely. in_valid is ignored, no word lost.
//  On return to FILL, out_flat keeps stale values in slots not yet
//   overwritten. Contents are defined only while out_valid=1.
//  N==1: every accepted word moves straight to HOLD; count stays 0.
//  count never exceeds N-1 and wraps to 0 only on the Nth acceptance.
// CONFIGURATION
//  ARRAY_PACK_CHECKSUM_EN defined:
//   - out_sum exists and accumulates a mod-2^WIDTH sum of accepted elements.
//   - The first word of an array loads the accumulator; later words add to it.
//   - out_sum equals the sum of all N elements whenever out_valid=1.
//   - It is held through HOLD and cleared to 0 by rst.
//  ARRAY_PACK_CHECKSUM_EN undefined:
//   - out_sum port and accumulator are absent. All other behaviour is identical.
// TESTING (N=5, WIDTH=8 unless stated)
//  1 Basic pack: stream 1,2,3,4,5 back-to-back with out_ready=1.
//    -> out_valid=1 one cycle after 5 is accepted; out_flat=0x0504030201.
//    -> in_ready=0 for exactly that cycle.
//  2 Gaps: stream 1..5 with in_valid low for 2 cycles between each word.
//    -> out_flat=0x0504030201; no early out_valid.
//  3 Backpressure: out_ready=0 for 10 cycles after the array completes;
//    drive in_valid=1, in_data=0xAA throughout.
//    -> out_flat stable at 0x0504030201; in_ready=0.
//    -> After out_ready=1, the next array starts with element 0.
//  4 Reset mid-fill: accept 1,2,3, assert rst, release, then stream 9,8,7,6,5.
//    -> out_flat=0x0506070809; out_valid=0 while rst is high.
//  5 Wrap/checksum (macro on): stream 0xFF,0xFF,0x02,0x00,0x01.
//    -> out_sum=0x01.
//    -> Second array 1..5 gives out_sum=0x0F (accumulator reloaded, not carried).
//  6 N=1, WIDTH=4: stream 0x3,0xC with out_ready=1.
//    -> out_flat=0x3, then 0xC; in_ready toggles 1,0 per word.

Source files
------------

// File: rtl/array_stream_packer.sv
// Serial-to-parallel packer: gathers N WIDTH-bit words into one flat array and holds it until accepted.
// Optional ARRAY_PACK_CHECKSUM_EN adds out_sum, a mod-2^WIDTH sum of the packed elements.

module array_stream_packer_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end
endmodule

module array_stream_packer #(
  parameter int N     = 5,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WIDTH-1:0] out_flat
`ifdef ARRAY_PACK_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]   out_sum
`endif
);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {FILL, HOLD} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       accept;
  logic                       last;
  logic [N-1:0][WIDTH-1:0]    elem;

  assign last = (count_q == CNT_W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Handshake flags come from state alone; no out_ready -> in_ready path.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          if (last) begin
            count_d = '0;
            state_d = HOLD;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  for (genvar i = 0; i < N; i++) begin : g_slot
    array_stream_packer_slot #(.WIDTH(WIDTH)) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (accept && (count_q == CNT_W'(i))),
      .d    (in_data),
      .q    (elem[i])
    );
  end

  assign out_flat = elem;

`ifdef ARRAY_PACK_CHECKSUM_EN
  // First word of each array reloads the sum so nothing carries across arrays.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         out_sum <= '0;
    else if (accept) out_sum <= (count_q == '0) ? in_data : out_sum + in_data;
  end
`endif
endmodule

// File: tb/tb_array_stream_packer.sv
// Randomized/directed bench for array_stream_packer (N=5/WIDTH=8 main instance, N=1/WIDTH=4 side instance).
module tb_array_stream_packer;
  localparam int N = 5;
  localparam int W = 8;

  logic clk = 0, rst = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [W-1:0] in_data = '0;
  logic [N*W-1:0] out_flat;
  logic v1 = 0, rdy1, ov1, or1 = 1;
  logic [3:0] d1 = '0, flat1;
`ifdef ARRAY_PACK_CHECKSUM_EN
  logic [W-1:0] out_sum;
  logic [3:0] sum1;
`endif

  int checks = 0, failures = 0;

  // reference model: list of accepted words plus the completed array
  int unsigned m_words[$];
  bit m_hold = 0;
  logic [N*W-1:0] m_arr = '0;
  logic [W-1:0] m_sum = '0;

  array_stream_packer #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_flat(out_flat)
`ifdef ARRAY_PACK_CHECKSUM_EN
    , .out_sum(out_sum)
`endif
  );

  array_stream_packer #(.N(1), .WIDTH(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_flat(flat1)
`ifdef ARRAY_PACK_CHECKSUM_EN
    , .out_sum(sum1)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_words.delete();
    m_hold = 0;
    m_arr = '0;
    m_sum = '0;
  endtask

  // drive one cycle of inputs, advance past the edge, then update the model
  task automatic tick(input logic iv, input logic [W-1:0] id, input logic ordy);
    in_valid = iv; in_data = id; out_ready = ordy;
    @(posedge clk); #1;
    if (!m_hold) begin
      if (iv) begin
        m_words.push_back(id);
        if (m_words.size() == N) begin
          int unsigned s = 0;
          for (int i = 0; i < N; i++) begin
            m_arr[i*W +: W] = W'(m_words[i]);
            s += m_words[i];
          end
          m_sum = W'(s % 256);
          m_words.delete();
          m_hold = 1;
        end
      end
    end else if (ordy) begin
      m_hold = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1; #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_flat !== '0) begin failures++; $display("FAIL reset_flat got=%h want=0", out_flat); end
    @(posedge clk); #1; rst = 0; model_reset();
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    checks++; if (rdy1 !== 1'b1 || ov1 !== 1'b0) begin failures++; $display("FAIL reset_n1 got rdy=%b vld=%b want 1/0", rdy1, ov1); end
`ifdef ARRAY_PACK_CHECKSUM_EN
    checks++; if (out_sum !== '0) begin failures++; $display("FAIL reset_sum got=%h want=0", out_sum); end
`endif
  endtask

  task automatic test_basic();
    for (int k = 1; k <= N; k++) begin
      tick(1, W'(k), 1);
      if (k < N) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early k=%0d got=%b want=0", k, out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL basic_hold got vld=%b rdy=%b want 1/0", out_valid, in_ready); end
    checks++; if (out_flat !== 40'h0504030201) begin failures++; $display("FAIL basic_flat got=%h want=0504030201", out_flat); end
    tick(0, 0, 1);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL basic_release got vld=%b rdy=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_gaps();
    for (int k = 1; k <= N; k++) begin
      tick(1, W'(k), 1);
      if (k < N) for (int g = 0; g < 2; g++) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL gaps_early k=%0d got=%b want=0", k, out_valid); end
        tick(0, 8'h77, 1);
      end
    end
    checks++; if (out_valid !== 1'b1 || out_flat !== m_arr || m_arr !== 40'h0504030201) begin
      failures++; $display("FAIL gaps_flat got vld=%b flat=%h want 1/0504030201", out_valid, out_flat); end
    tick(0, 0, 1);
  endtask

  task automatic test_backpressure();
    for (int k = 1; k <= N; k++) tick(1, W'(k), 0);
    for (int c = 0; c < 10; c++) begin
      tick(1, 8'hAA, 0);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_flat !== 40'h0504030201) begin
        failures++; $display("FAIL bp_hold c=%0d got vld=%b rdy=%b flat=%h want 1/0/0504030201", c, out_valid, in_ready, out_flat); end
    end
    tick(1, 8'hAA, 1);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got vld=%b rdy=%b want 0/1", out_valid, in_ready); end
    for (int k = 0; k < N; k++) tick(1, W'(8'h10 + k), 1);
    checks++; if (out_flat !== 40'h1413121110 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_next got=%h want=1413121110", out_flat); end
    tick(0, 0, 1);
  endtask

  task automatic test_reset_midfill();
    tick(1, 1, 1); tick(1, 2, 1); tick(1, 3, 1);
    rst = 1; #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b want=0", out_valid); end
    tick(1, 8'h44, 1);
    checks++; if (out_valid !== 1'b0 || out_flat !== '0) begin failures++; $display("FAIL rst_mid_held got vld=%b flat=%h want 0/0", out_valid, out_flat); end
    rst = 0; model_reset();
    tick(0, 0, 1);
    for (int k = 9; k >= 5; k--) tick(1, W'(k), 1);
    checks++; if (out_valid !== 1'b1 || out_flat !== 40'h0506070809) begin failures++; $display("FAIL rst_mid_flat got=%h want=0506070809", out_flat); end
    tick(0, 0, 1);
  endtask

`ifdef ARRAY_PACK_CHECKSUM_EN
  task automatic test_checksum();
    logic [W-1:0] seq [N];
    seq = '{8'hFF, 8'hFF, 8'h02, 8'h00, 8'h01};
    for (int k = 0; k < N; k++) tick(1, seq[k], 1);
    checks++; if (out_sum !== 8'h01) begin failures++; $display("FAIL sum_wrap got=%h want=01", out_sum); end
    tick(0, 0, 1);
    for (int k = 1; k <= N; k++) tick(1, W'(k), 1);
    checks++; if (out_sum !== 8'h0F) begin failures++; $display("FAIL sum_reload got=%h want=0F", out_sum); end
    tick(0, 0, 1);
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick(1'($urandom_range(0, 99) < 60), W'($urandom), 1'($urandom_range(0, 99) < 50));
      checks++; if (out_valid !== m_hold || in_ready !== !m_hold) begin
        failures++; $display("FAIL rand_flags c=%0d got vld=%b rdy=%b want %b/%b", c, out_valid, in_ready, m_hold, !m_hold); end
      if (m_hold) begin
        checks++; if (out_flat !== m_arr) begin failures++; $display("FAIL rand_flat c=%0d got=%h want=%h", c, out_flat, m_arr); end
`ifdef ARRAY_PACK_CHECKSUM_EN
        checks++; if (out_sum !== m_sum) begin failures++; $display("FAIL rand_sum c=%0d got=%h want=%h", c, out_sum, m_sum); end
`endif
      end
    end
    while (m_hold) tick(0, 0, 1);
  endtask

  task automatic test_n1();
    v1 = 1; d1 = 4'h3; or1 = 1;
    tick(0, 0, 1);
    checks++; if (ov1 !== 1'b1 || rdy1 !== 1'b0 || flat1 !== 4'h3) begin failures++; $display("FAIL n1_first got vld=%b rdy=%b flat=%h want 1/0/3", ov1, rdy1, flat1); end
    d1 = 4'hC;
    tick(0, 0, 1);
    checks++; if (ov1 !== 1'b0 || rdy1 !== 1'b1) begin failures++; $display("FAIL n1_release got vld=%b rdy=%b want 0/1", ov1, rdy1); end
    tick(0, 0, 1);
    checks++; if (ov1 !== 1'b1 || rdy1 !== 1'b0 || flat1 !== 4'hC) begin failures++; $display("FAIL n1_second got vld=%b rdy=%b flat=%h want 1/0/C", ov1, rdy1, flat1); end
    v1 = 0;
    tick(0, 0, 1);
    checks++; if (ov1 !== 1'b0 || rdy1 !== 1'b1) begin failures++; $display("FAIL n1_idle got vld=%b rdy=%b want 0/1", ov1, rdy1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_reset_midfill();
`ifdef ARRAY_PACK_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    test_n1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
